// File: rtl/mem_port_arbiter.sv
// Arbiter sharing a single-port 256x8 memory between instruction fetch and data access.
// Build option MEM_ARB_RR_EN: round-robin on contended slots instead of DM priority + starvation guard.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       if_req_i,
  input  logic [7:0] if_addr_i,
  output logic       if_gnt_o,
  output logic       if_rvalid_o,
  output logic [7:0] if_rdata_o,
  input  logic       dm_req_i,
  input  logic       dm_we_i,
  input  logic [7:0] dm_addr_i,
  input  logic [7:0] dm_wdata_i,
  output logic       dm_gnt_o,
  output logic       dm_rvalid_o,
  output logic [7:0] dm_rdata_o,
  output logic       mem_en_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_wdata_o,
  input  logic [7:0] mem_rdata_i,
  output logic       stall_f_o
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;
  typedef enum logic {OwnIf, OwnDm} owner_e;

  localparam logic [1:0] CntInit = 2'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  owner_e     owner_q, owner_d;

  logic slot_open, resp_valid;
  logic if_pri, if_win, dm_win;
  logic if_gnt, dm_gnt;

  assign slot_open  = (state_q == StIdle) || (cnt_q == 2'd0);
  assign resp_valid = (state_q == StRdWait) && (cnt_q == 2'd0);

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  // IF gets a contended slot only when DM won the previous grant.
  assign if_pri = (last_q == OwnDm);

  always_comb begin
    last_d = last_q;
    if (if_gnt) begin
      last_d = OwnIf;
    end else if (dm_gnt) begin
      last_d = OwnDm;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= OwnIf;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  assign if_pri = (starve_q == StarveMax);

  always_comb begin
    starve_d = 4'd0;
    if (if_req_i && !if_gnt) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Grants are held off during reset so every output reads 0.
  always_comb begin
    if_win = if_req_i && (!dm_req_i || if_pri);
    dm_win = dm_req_i && !if_win;
    if_gnt = !reset_i && slot_open && if_win;
    dm_gnt = !reset_i && slot_open && dm_win;
  end

  always_comb begin
    if_gnt_o    = if_gnt;
    dm_gnt_o    = dm_gnt;
    mem_en_o    = if_gnt || dm_gnt;
    mem_we_o    = dm_gnt && dm_we_i;
    mem_addr_o  = 8'd0;
    mem_wdata_o = 8'd0;
    if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end else if (dm_gnt) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
    if_rvalid_o = !reset_i && resp_valid && (owner_q == OwnIf);
    dm_rvalid_o = !reset_i && resp_valid && (owner_q == OwnDm);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 8'd0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : 8'd0;
    stall_f_o   = !reset_i && if_req_i && !if_gnt;
  end

  always_comb begin
    state_d = StIdle;
    cnt_d   = 2'd0;
    owner_d = owner_q;
    if (if_gnt || (dm_gnt && !dm_we_i)) begin
      state_d = StRdWait;
      cnt_d   = CntInit;
      owner_d = if_gnt ? OwnIf : OwnDm;
    end else if ((state_q == StRdWait) && (cnt_q != 2'd0)) begin
      state_d = StRdWait;
      cnt_d   = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      owner_q <= OwnIf;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

endmodule
